// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter.
// Provides the arbiter FSM state encoding, the access owner encoding and
// the default address width and frame buffer base address.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  typedef enum logic {
    OwnVid,
    OwnCpu
  } owner_e;

  localparam int unsigned DefAw      = 16;
  localparam logic [15:0] DefVidBase = 16'hD380;

endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port 16-bit RAM between the video fetcher
// and the CPU bus. Accesses are serialised by a registered IDLE/WAIT/DONE FSM;
// video wins ties. Each access ends with a one-cycle ack carrying read data.
//
// Optional build macro ARB_CPU_FAIR_EN: after FAIR_LIMIT consecutive lost ties
// the CPU wins the next tie. Without it video always wins ties.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   vid_req/vid_addr           video fetch request, 14-bit word offset
//   vid_ack/vid_dout           video completion pulse and fetched word
//   cpu_req/we/addr/din/be     CPU request, direction, address, data, byte enables
//   cpu_ack/cpu_dout           CPU completion pulse and read data
//   ram_addr/din/we/be         registered RAM command
//   ram_dout                   RAM read data, RAM_LAT cycles after ram_addr
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned   AW         = DefAw,
  parameter logic [AW-1:0] VID_BASE   = AW'(DefVidBase),
  parameter int unsigned   RAM_LAT    = 1,
  parameter int unsigned   FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [13:0]   vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_be,
  output logic          cpu_ack,
  output logic [15:0]   cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_din,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  input  logic [15:0]   ram_dout
);

  if (RAM_LAT < 1 || RAM_LAT > 7) begin : g_bad_lat
    $error("RAM_LAT must be in 1..7");
  end
  // The loss counter saturates at 7, so a larger limit could never trigger.
  if (FAIR_LIMIT > 7) begin : g_bad_fair
    $error("FAIR_LIMIT must be <= 7");
  end

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          owner_we_q, owner_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]   ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic [1:0]    ram_be_q, ram_be_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [15:0]   vid_dout_q, vid_dout_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;
  logic          cpu_grant;

`ifdef ARB_CPU_FAIR_EN
  logic [2:0] fair_q, fair_d;

  assign cpu_grant = cpu_req && (!vid_req || (32'(fair_q) >= FAIR_LIMIT));
`else
  assign cpu_grant = cpu_req && !vid_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    owner_we_d = owner_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;  // write strobe lasts only the first WAIT cycle
    ram_be_d   = ram_be_q;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    vid_dout_d = vid_dout_q;
    cpu_dout_d = cpu_dout_q;
`ifdef ARB_CPU_FAIR_EN
    fair_d     = fair_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (vid_req || cpu_req) begin
          state_d = StWait;
          cnt_d   = 3'(RAM_LAT);
          if (cpu_grant) begin
            owner_d    = OwnCpu;
            owner_we_d = cpu_we;
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_din;
            ram_be_d   = cpu_be;
            ram_we_d   = cpu_we;
`ifdef ARB_CPU_FAIR_EN
            fair_d     = 3'd0;
`endif
          end else begin
            owner_d    = OwnVid;
            owner_we_d = 1'b0;
            // Wraps modulo 2^AW by construction of the AW-bit sum.
            ram_addr_d = VID_BASE + AW'(vid_addr);
            ram_be_d   = 2'b11;
`ifdef ARB_CPU_FAIR_EN
            if (cpu_req && fair_q != 3'd7) fair_d = fair_q + 3'd1;
`endif
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StDone;
          if (owner_q == OwnVid) begin
            vid_ack_d  = 1'b1;
            vid_dout_d = ram_dout;
          end else begin
            cpu_ack_d = 1'b1;
            if (!owner_we_q) cpu_dout_d = ram_dout;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= OwnVid;
      cnt_q      <= 3'd0;
      owner_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_be_q   <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_dout_q <= '0;
      cpu_dout_q <= '0;
`ifdef ARB_CPU_FAIR_EN
      fair_q     <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      owner_we_q <= owner_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_be_q   <= ram_be_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_dout_q <= vid_dout_d;
      cpu_dout_q <= cpu_dout_d;
`ifdef ARB_CPU_FAIR_EN
      fair_q     <= fair_d;
`endif
    end
  end

  assign vid_ack  = vid_ack_q;
  assign vid_dout = vid_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign ram_be   = ram_be_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a RAM model with RAM_LAT read latency,
// a transaction-level reference that predicts each grant, its ack edge, the
// RAM address and the returned data, and a monitor that pops predictions as
// acks appear.
module tb_vram_arbiter;

  localparam int unsigned RAM_LAT    = 1;
  localparam int unsigned FAIR_LIMIT = 4;
  localparam logic [15:0] VID_BASE   = 16'hD380;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_dout;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [1:0]  cpu_be = '0;
  logic        cpu_ack;
  logic [15:0] cpu_dout;
  logic [15:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_dout;

  vram_arbiter #(
    .AW        (16),
    .VID_BASE  (VID_BASE),
    .RAM_LAT   (RAM_LAT),
    .FAIR_LIMIT(FAIR_LIMIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .vid_req (vid_req),
    .vid_addr(vid_addr),
    .vid_ack (vid_ack),
    .vid_dout(vid_dout),
    .cpu_req (cpu_req),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_be  (cpu_be),
    .cpu_ack (cpu_ack),
    .cpu_dout(cpu_dout),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_we  (ram_we),
    .ram_be  (ram_be),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // RAM model driving ram_dout, read-first, RAM_LAT cycle latency.
  logic [15:0] ram_mem [0:65535];
  logic [15:0] pipe [0:7];
  assign ram_dout = pipe[RAM_LAT-1];

  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = init_word(i);
    ram_mem[16'hD385] = 16'hA5A5;
    for (int i = 0; i < 8; i++) pipe[i] = '0;
    forever begin
      @(posedge clk);
      pipe[0] <= ram_mem[ram_addr];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (ram_we) begin
        if (ram_be[1]) ram_mem[ram_addr][15:8] = ram_din[15:8];
        if (ram_be[0]) ram_mem[ram_addr][7:0] = ram_din[7:0];
      end
    end
  end

  // Reference: one access at a time; an access granted at edge g acks at
  // edge g+RAM_LAT+1 and the next grant may happen at edge g+RAM_LAT+3.
  typedef struct {
    bit          is_cpu;
    logic [15:0] data;
    logic [15:0] addr;
    int          ack_edge;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [0:65535];
  int          cyc = 0;
  int          free_edge = 0;
  logic [15:0] exp_cpu = '0;
  int          tie_losses = 0;

  initial begin
    exp_t e;
    bit   cpu_wins;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    ref_mem[16'hD385] = 16'hA5A5;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        free_edge  = cyc + 1;
        exp_cpu    = '0;
        tie_losses = 0;
      end else if (cyc >= free_edge && (vid_req || cpu_req)) begin
        cpu_wins = !vid_req;
`ifdef ARB_CPU_FAIR_EN
        if (vid_req && cpu_req && tie_losses >= int'(FAIR_LIMIT)) cpu_wins = 1'b1;
`endif
        e.ack_edge = cyc + RAM_LAT + 1;
        free_edge  = cyc + RAM_LAT + 3;
        e.is_cpu   = cpu_wins;
        if (cpu_wins) begin
          tie_losses = 0;
          e.addr = cpu_addr;
          if (cpu_we) begin
            if (cpu_be[1]) ref_mem[cpu_addr][15:8] = cpu_din[15:8];
            if (cpu_be[0]) ref_mem[cpu_addr][7:0] = cpu_din[7:0];
          end else begin
            exp_cpu = ref_mem[cpu_addr];
          end
          e.data = exp_cpu;
        end else begin
          if (cpu_req && tie_losses < 7) tie_losses++;
          e.addr = 16'(32'(VID_BASE) + 32'(vid_addr));
          e.data = ref_mem[e.addr];
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares each ack against the oldest prediction.
  int we_run = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_we) we_run++;
      else if (we_run != 0) begin
        check("ram_we_len", 32'(we_run), 32'd1);
        we_run = 0;
      end
      if (!reset) begin
        if (vid_ack || cpu_ack) begin
          check("single_ack", 32'(vid_ack && cpu_ack), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", {30'd0, vid_ack, cpu_ack}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_owner", 32'(cpu_ack), 32'(e.is_cpu));
            check("ack_edge", 32'(cyc), 32'(e.ack_edge));
            check("ack_addr", 32'(ram_addr), 32'(e.addr));
            if (e.is_cpu) check("cpu_dout", 32'(cpu_dout), 32'(e.data));
            else check("vid_dout", 32'(vid_dout), 32'(e.data));
          end
        end else if (exp_q.size() != 0 && exp_q[0].ack_edge < cyc) begin
          e = exp_q.pop_front();
          check("missing_ack", 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic do_vid(input int dly, input logic [13:0] a);
    int n;
    repeat (dly) @(negedge clk);
    vid_addr = a;
    vid_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vid_ack && n < 80);
    if (!vid_ack) check("vid_timeout", 32'd0, 32'd1);
    vid_req = 1'b0;
  endtask

  task automatic do_cpu(input int dly, input logic [15:0] a, input logic we,
                        input logic [15:0] d, input logic [1:0] be);
    int n;
    repeat (dly) @(negedge clk);
    cpu_addr = a;
    cpu_we   = we;
    cpu_din  = d;
    cpu_be   = be;
    cpu_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 80);
    if (!cpu_ack) check("cpu_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_vid_dout", 32'(vid_dout), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
  endtask

  logic [13:0] va;
  logic [15:0] ca, cd;
  logic        cw;
  logic [1:0]  cb;
  int          k;

  initial begin
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    // Start a CPU read, then reset during its WAIT phase: no ack may follow.
    reset    = 1'b0;
    cpu_addr = 16'h0104;
    cpu_we   = 1'b0;
    cpu_be   = 2'b11;
    cpu_req  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_ack && k < 20);
    if (!cpu_ack) check("cpu_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: video read, CPU byte write and readback, tie, address wrap.
    do_vid(0, 14'h0005);
    do_cpu(1, 16'h0100, 1'b1, 16'h1234, 2'b10);
    do_cpu(0, 16'h0100, 1'b0, 16'h0000, 2'b11);
    fork
      do_vid(1, 14'h0002);
      do_cpu(1, 16'hD382, 1'b1, 16'hBEEF, 2'b11);
    join
    do_vid(0, 14'h0002);
    do_vid(2, 14'h3FFF);

    // Continuous video demand with a CPU request pending throughout.
    fork
      repeat (6) do_vid(0, 14'h0001);
      repeat (3) do_cpu(0, 16'h0101, 1'b0, 16'h0000, 2'b11);
    join

    for (int i = 0; i < 150; i++) begin
      k  = int'($urandom_range(0, 2));
      va = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
      ca = ($urandom_range(0, 1) == 1) ? 16'h0100 + 16'($urandom_range(0, 7))
                                       : 16'hD380 + 16'($urandom_range(0, 7));
      cw = 1'($urandom_range(0, 1));
      cd = 16'($urandom);
      cb = 2'($urandom_range(0, 3));
      fork
        if (k != 1) do_vid(int'($urandom_range(0, 3)), va);
        if (k != 0) do_cpu(int'($urandom_range(0, 3)), ca, cw, cd, cb);
      join
    end

    repeat (10) @(negedge clk);
    check("drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
